// File: rtl/machine.sv
// Single-cycle MIPS-subset machine: combinational fetch, decode and execute.
// Each rising clock edge retires one instruction.

module pc_reg #(
    parameter logic [29:0] RESET_WORD = '0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [29:0] d_i,
    output logic [29:0] q_o
);
    logic [29:0] q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) q <= RESET_WORD;
        else         q <= d_i;
    end

    assign q_o = q;
endmodule

module regfile (
    input  logic        clk_i,
    input  logic        we_i,
    input  logic [4:0]  ra1_i,
    input  logic [4:0]  ra2_i,
    input  logic [4:0]  wa_i,
    input  logic [31:0] wd_i,
    output logic [31:0] rd1_o,
    output logic [31:0] rd2_o
);
    logic [31:0] r [0:31];

    // r[0] is pinned to zero so the array itself always shows the hardwired value.
    always_ff @(posedge clk_i) begin
        r[0] <= '0;
        if (we_i && (wa_i != 5'd0)) r[wa_i] <= wd_i;
    end

    assign rd1_o = (ra1_i == 5'd0) ? '0 : r[ra1_i];
    assign rd2_o = (ra2_i == 5'd0) ? '0 : r[ra2_i];
endmodule

module data_memory #(
    parameter logic [31:0] DATA_BASE  = 32'h1000_0000,
    parameter int unsigned DATA_WORDS = 65536
) (
    input  logic        clk_i,
    input  logic        we_i,
    input  logic [29:0] waddr_i,
    input  logic [31:0] wd_i,
    output logic [31:0] rd_o
);
    localparam int unsigned AW = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;

    logic [31:0] data_seg [0:DATA_WORDS-1];
    logic [29:0] word_off;
    logic        in_range;

    assign word_off = waddr_i - DATA_BASE[31:2];
    assign in_range = ({2'b00, word_off} < 32'(DATA_WORDS));
    assign rd_o     = in_range ? data_seg[word_off[AW-1:0]] : '0;

    always_ff @(posedge clk_i) begin
        if (we_i && in_range) data_seg[word_off[AW-1:0]] <= wd_i;
    end
endmodule

module machine #(
    parameter logic [31:0] TEXT_BASE  = 32'h0040_0000,
    parameter logic [31:0] DATA_BASE  = 32'h1000_0000,
    parameter int unsigned DATA_WORDS = 65536,
    parameter int unsigned TEXT_WORDS = 1024
) (
    input logic clk,
    input logic reset
);
    localparam int unsigned TW = (TEXT_WORDS > 1) ? $clog2(TEXT_WORDS) : 1;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03, OP_BEQ  = 6'h04,
        OP_BNE   = 6'h05, OP_ADDI = 6'h08, OP_SLTI = 6'h0a, OP_ANDI = 6'h0c,
        OP_ORI   = 6'h0d, OP_LUI  = 6'h0f, OP_JRLM = 6'h1d, OP_LW   = 6'h23,
        OP_SW    = 6'h2b
    } opcode_e;

    typedef enum logic [5:0] {
        FN_SLL = 6'h00, FN_SRL = 6'h02, FN_JR  = 6'h08, FN_ADD = 6'h20,
        FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR  = 6'h25, FN_NOR = 6'h27,
        FN_SLT = 6'h2a
    } funct_e;

    logic [29:0] pc_q, pc_d;
    logic [31:0] pc4;
    logic [31:0] inst;
    logic [29:0] text_off;
    logic        text_hit;
    logic [31:0] rs_val, rt_val, sext_imm, zext_imm, ea, dm_rd;
    logic        rf_we, dm_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;

    // Text is loaded hierarchically by the environment; reset empties it so
    // unloaded words fetch as zero.
    logic [31:0] text [0:TEXT_WORDS-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < TEXT_WORDS; i++) text[i] <= '0;
        end
    end

    pc_reg #(.RESET_WORD(TEXT_BASE[31:2])) PC_reg (
        .clk_i (clk),
        .rst_ni(reset),
        .d_i   (pc_d),
        .q_o   (pc_q)
    );

    assign text_off = pc_q - TEXT_BASE[31:2];
    assign text_hit = ({2'b00, text_off} < 32'(TEXT_WORDS));
    assign inst     = text_hit ? text[text_off[TW-1:0]] : '0;

    assign pc4      = {pc_q, 2'b00} + 32'd4;
    assign sext_imm = {{16{inst[15]}}, inst[15:0]};
    assign zext_imm = {16'h0000, inst[15:0]};
    assign ea       = rs_val + sext_imm;

    // Writes are masked while reset is low so an interrupted cycle leaves no trace.
    regfile rf (
        .clk_i(clk),
        .we_i (rf_we & reset),
        .ra1_i(inst[25:21]),
        .ra2_i(inst[20:16]),
        .wa_i (rf_wa),
        .wd_i (rf_wd),
        .rd1_o(rs_val),
        .rd2_o(rt_val)
    );

    data_memory #(.DATA_BASE(DATA_BASE), .DATA_WORDS(DATA_WORDS)) data_memory (
        .clk_i  (clk),
        .we_i   (dm_we & reset),
        .waddr_i(ea[31:2]),
        .wd_i   (rt_val),
        .rd_o   (dm_rd)
    );

    always_comb begin
        pc_d  = pc4[31:2];
        rf_we = 1'b0;
        rf_wa = '0;
        rf_wd = '0;
        dm_we = 1'b0;
        case (inst[31:26])
            OP_RTYPE: begin
                rf_wa = inst[15:11];
                case (inst[5:0])
                    FN_ADD: begin rf_we = 1'b1; rf_wd = rs_val + rt_val;    end
                    FN_SUB: begin rf_we = 1'b1; rf_wd = rs_val - rt_val;    end
                    FN_AND: begin rf_we = 1'b1; rf_wd = rs_val & rt_val;    end
                    FN_OR:  begin rf_we = 1'b1; rf_wd = rs_val | rt_val;    end
                    FN_NOR: begin rf_we = 1'b1; rf_wd = ~(rs_val | rt_val); end
                    FN_SLT: begin
                        rf_we = 1'b1;
                        rf_wd = {31'b0, $signed(rs_val) < $signed(rt_val)};
                    end
                    FN_SLL: begin rf_we = 1'b1; rf_wd = rt_val << inst[10:6]; end
                    FN_SRL: begin rf_we = 1'b1; rf_wd = rt_val >> inst[10:6]; end
                    FN_JR:  pc_d = rs_val[31:2];
                    default: ;
                endcase
            end
            OP_ADDI: begin rf_we = 1'b1; rf_wa = inst[20:16]; rf_wd = ea;                   end
            OP_ANDI: begin rf_we = 1'b1; rf_wa = inst[20:16]; rf_wd = rs_val & zext_imm;    end
            OP_ORI:  begin rf_we = 1'b1; rf_wa = inst[20:16]; rf_wd = rs_val | zext_imm;    end
            OP_LUI:  begin rf_we = 1'b1; rf_wa = inst[20:16]; rf_wd = {inst[15:0], 16'h0}; end
            OP_SLTI: begin
                rf_we = 1'b1;
                rf_wa = inst[20:16];
                rf_wd = {31'b0, $signed(rs_val) < $signed(sext_imm)};
            end
            OP_LW:   begin rf_we = 1'b1; rf_wa = inst[20:16]; rf_wd = dm_rd; end
            OP_SW:   dm_we = 1'b1;
            OP_BEQ:  if (rs_val == rt_val) pc_d = pc4[31:2] + sext_imm[29:0];
            OP_BNE:  if (rs_val != rt_val) pc_d = pc4[31:2] + sext_imm[29:0];
            OP_J:    pc_d = {pc4[31:28], inst[25:0]};
            OP_JAL: begin
                pc_d  = {pc4[31:28], inst[25:0]};
                rf_we = 1'b1;
                rf_wa = 5'd31;
                rf_wd = pc4;
            end
            OP_JRLM: begin
                pc_d  = ea[31:2];
                rf_we = 1'b1;
                rf_wa = inst[20:16];
                rf_wd = pc4;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_machine.sv
// Self-checking bench for machine: directed programs with literal expectations
// plus random programs checked cycle-by-cycle against an instruction-level model.

module tb_machine;
    localparam logic [31:0] TEXT_BASE  = 32'h0040_0000;
    localparam logic [31:0] DATA_BASE  = 32'h1000_0000;
    localparam int          DATA_WORDS = 65536;
    localparam int          TEXT_WORDS = 1024;
    localparam int          PROG_LEN   = 24;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    machine #(
        .TEXT_BASE (TEXT_BASE),
        .DATA_BASE (DATA_BASE),
        .DATA_WORDS(DATA_WORDS),
        .TEXT_WORDS(TEXT_WORDS)
    ) dut (
        .clk  (clk),
        .reset(reset)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mreg [32];
    logic [31:0] mpc;
    logic [31:0] mtext [int];
    logic [31:0] mmem  [int];
    bit          run_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(int rs, int rt, int rd, int sh, int fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction

    function automatic logic [31:0] enc_i(int op, int rs, int rt, int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] enc_j(int op, logic [31:0] target);
        return {6'(op), target[27:2]};
    endfunction

    // ---------------- instruction-level reference model ----------------
    function automatic logic [31:0] m_fetch(logic [31:0] pc);
        longint off = longint'(pc) - longint'(TEXT_BASE);
        if (off < 0 || off >= 4 * longint'(TEXT_WORDS)) return 32'h0;
        if (!mtext.exists(int'(off / 4))) return 32'h0;
        return mtext[int'(off / 4)];
    endfunction

    function automatic bit m_dindex(logic [31:0] addr, output int idx);
        longint off = longint'({addr[31:2], 2'b00}) - longint'(DATA_BASE);
        idx = int'(off / 4);
        return (off >= 0) && (off < 4 * longint'(DATA_WORDS));
    endfunction

    task automatic model_step();
        logic [31:0] in, a, b, sx, zx, pc4, nxt, ea, wd;
        int op, fn, rs, rt, rd, sh, wa, idx;
        bit we;
        in = m_fetch(mpc);
        op = int'(in[31:26]); fn = int'(in[5:0]);
        rs = int'(in[25:21]); rt = int'(in[20:16]); rd = int'(in[15:11]); sh = int'(in[10:6]);
        a  = (rs == 0) ? 32'h0 : mreg[rs];
        b  = (rt == 0) ? 32'h0 : mreg[rt];
        sx = {{16{in[15]}}, in[15:0]};
        zx = {16'h0, in[15:0]};
        pc4 = mpc + 32'd4;
        nxt = pc4;
        ea  = a + sx;
        we = 1'b0; wa = 0; wd = 32'h0;
        case (op)
            'h00: begin
                wa = rd; we = 1'b1;
                case (fn)
                    'h20: wd = a + b;
                    'h22: wd = a - b;
                    'h24: wd = a & b;
                    'h25: wd = a | b;
                    'h27: wd = ~(a | b);
                    'h2a: wd = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    'h00: wd = b << sh;
                    'h02: wd = b >> sh;
                    'h08: begin we = 1'b0; nxt = a & 32'hFFFF_FFFC; end
                    default: we = 1'b0;
                endcase
            end
            'h08: begin we = 1'b1; wa = rt; wd = ea; end
            'h0c: begin we = 1'b1; wa = rt; wd = a & zx; end
            'h0d: begin we = 1'b1; wa = rt; wd = a | zx; end
            'h0f: begin we = 1'b1; wa = rt; wd = {in[15:0], 16'h0}; end
            'h0a: begin we = 1'b1; wa = rt; wd = ($signed(a) < $signed(sx)) ? 32'd1 : 32'd0; end
            'h23: begin
                we = 1'b1; wa = rt;
                if (m_dindex(ea, idx) && mmem.exists(idx)) wd = mmem[idx];
                else wd = 32'h0;
            end
            'h2b: if (m_dindex(ea, idx)) mmem[idx] = b;
            'h04: if (a == b) nxt = pc4 + (sx << 2);
            'h05: if (a != b) nxt = pc4 + (sx << 2);
            'h02: nxt = {pc4[31:28], in[25:0], 2'b00};
            'h03: begin nxt = {pc4[31:28], in[25:0], 2'b00}; we = 1'b1; wa = 31; wd = pc4; end
            'h1d: begin nxt = ea & 32'hFFFF_FFFC; we = 1'b1; wa = rt; wd = pc4; end
            default: ;
        endcase
        if (we && wa != 0) mreg[wa] = wd;
        mpc = nxt;
    endtask

    // Model advances on each retiring edge; the DUT is compared a few ns later.
    always @(posedge clk) begin
        if (run_en) begin
            if (reset) model_step();
            #3;
            check("pc", {dut.PC_reg.q, 2'b00}, mpc);
            check("inst", dut.inst, m_fetch(mpc));
            for (int i = 0; i < 32; i++)
                check($sformatf("r%0d", i), dut.rf.r[i], (i == 0) ? 32'h0 : mreg[i]);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_reg(int i, logic [31:0] v);
        dut.rf.r[i] = v;
        mreg[i] = v;
    endtask

    task automatic put_text(int idx, logic [31:0] w);
        dut.text[idx] = w;
        mtext[idx] = w;
    endtask

    task automatic put_mem(int idx, logic [31:0] v);
        dut.data_memory.data_seg[idx] = v;
        mmem[idx] = v;
    endtask

    task automatic begin_test();
        run_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        mpc = TEXT_BASE;
        mtext.delete();
        @(negedge clk);
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] rand_inst();
        int d    = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(2, 7));
        int s    = int'($urandom_range(0, 9));
        int t    = int'($urandom_range(0, 9));
        int base = ($urandom_range(0, 1) == 1) ? 1 : 9;
        int off  = 4 * int'($urandom_range(0, 15)) + int'($urandom_range(0, 3));
        int imm  = int'($urandom_range(0, 65535));
        logic [31:0] w;
        case ($urandom_range(0, 19))
            0:  w = enc_r(s, t, d, 0, 'h20);
            1:  w = enc_r(s, t, d, 0, 'h22);
            2:  w = enc_r(s, t, d, 0, 'h24);
            3:  w = enc_r(s, t, d, 0, 'h25);
            4:  w = enc_r(s, t, d, 0, 'h27);
            5:  w = enc_r(s, t, d, 0, 'h2a);
            6:  w = enc_r(0, t, d, int'($urandom_range(0, 31)), 'h00);
            7:  w = enc_r(0, t, d, int'($urandom_range(0, 31)), 'h02);
            8:  w = enc_i('h08, s, d, imm);
            9:  w = enc_i('h0c, s, d, imm);
            10: w = enc_i('h0d, s, d, imm);
            11: w = enc_i('h0f, 0, d, imm);
            12: w = enc_i('h0a, s, d, imm);
            13: w = enc_i('h23, base, d, off);
            14: w = enc_i('h2b, base, t, off);
            15: w = enc_i('h04, s, t, int'($urandom_range(0, 6)) - 3);
            16: w = enc_i('h05, s, t, int'($urandom_range(0, 6)) - 3);
            17: w = enc_j(($urandom_range(0, 1) == 1) ? 'h03 : 'h02,
                          TEXT_BASE + 32'(4 * $urandom_range(0, PROG_LEN - 1)));
            18: w = ($urandom_range(0, 1) == 1) ? enc_i('h1d, 8, d, int'($urandom_range(0, 15)))
                                                : enc_r(8, 0, 0, 0, 'h08);
            default: w = ($urandom_range(0, 1) == 1) ? enc_i('h3f, s, d, imm)
                                                     : enc_r(s, t, d, 0, 'h3f);
        endcase
        return w;
    endfunction

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        for (int i = 0; i < 32; i++) mreg[i] = 32'h0;
        mpc = TEXT_BASE;

        // Reset value and a single add
        begin_test();
        for (int i = 1; i < 32; i++) set_reg(i, 32'h0);
        set_reg(1, 32'd5);
        set_reg(2, 32'd7);
        release_reset();
        put_text(0, enc_r(1, 2, 3, 0, 'h20));
        check("pc_reset_word", 32'(dut.PC_reg.q), 32'h0010_0000);
        check("pc_reset", {dut.PC_reg.q, 2'b00}, 32'h0040_0000);
        run_en = 1'b1;
        step(1);
        check("add_pc", {dut.PC_reg.q, 2'b00}, 32'h0040_0004);
        check("add_r3", dut.rf.r[3], 32'd12);

        // jrlm r2, 8(r3)
        begin_test();
        set_reg(3, 32'h0040_0200);
        set_reg(15, 32'h0040_0108);
        release_reset();
        put_text(0, enc_i('h1d, 3, 2, 8));
        run_en = 1'b1;
        step(1);
        check("jrlm_pc", {dut.PC_reg.q, 2'b00}, 32'h0040_0208);
        check("jrlm_r2", dut.rf.r[2], 32'h0040_0004);

        // jrlm r15, -8(r15): target from old r15
        begin_test();
        release_reset();
        put_text(0, enc_i('h1d, 15, 15, -8));
        run_en = 1'b1;
        step(1);
        check("jrlm_same_pc", {dut.PC_reg.q, 2'b00}, 32'h0040_0100);
        check("jrlm_same_r15", dut.rf.r[15], 32'h0040_0004);

        // jrlm r0, -10(r5): misaligned sum, link discarded
        begin_test();
        set_reg(5, 32'h0040_0030);
        release_reset();
        put_text(0, enc_i('h1d, 5, 0, -10));
        run_en = 1'b1;
        step(1);
        check("jrlm_r0_pc", {dut.PC_reg.q, 2'b00}, 32'h0040_0024);
        check("jrlm_r0_r0", dut.rf.r[0], 32'h0);

        // Memory round trip plus an out-of-range load
        begin_test();
        release_reset();
        put_text(0, enc_i('h0f, 0, 1, 'h1001));
        put_text(1, enc_i('h08, 0, 2, 5));
        put_text(2, enc_i('h2b, 1, 2, 0));
        put_text(3, enc_i('h23, 1, 4, 0));
        put_text(4, enc_i('h08, 0, 6, -1));
        put_text(5, enc_i('h23, 0, 6, 0));
        run_en = 1'b1;
        step(4);
        check("lui_r1", dut.rf.r[1], 32'h1001_0000);
        check("sw_mem", dut.data_memory.data_seg[32'h4000], 32'd5);
        check("lw_r4", dut.rf.r[4], 32'd5);
        step(1);
        check("addi_neg", dut.rf.r[6], 32'hFFFF_FFFF);
        step(1);
        check("lw_oob", dut.rf.r[6], 32'h0);

        // Branches, call and return, then halt on an empty word
        begin_test();
        set_reg(3, 32'h0000_dead);
        release_reset();
        put_text(0, enc_i('h08, 0, 1, 3));
        put_text(1, enc_i('h08, 0, 2, 3));
        put_text(2, enc_i('h04, 1, 2, 1));
        put_text(3, enc_i('h08, 0, 3, 99));
        put_text(4, enc_i('h05, 1, 2, 1));
        put_text(5, enc_j('h03, 32'h0040_0020));
        put_text(6, enc_i('h08, 0, 5, 7));
        put_text(8, enc_i('h08, 0, 4, 1));
        put_text(9, enc_r(31, 0, 0, 0, 'h08));
        run_en = 1'b1;
        step(3);
        check("beq_taken_pc", {dut.PC_reg.q, 2'b00}, 32'h0040_0010);
        step(1);
        check("bne_not_taken_pc", {dut.PC_reg.q, 2'b00}, 32'h0040_0014);
        step(1);
        check("jal_pc", {dut.PC_reg.q, 2'b00}, 32'h0040_0020);
        check("jal_r31", dut.rf.r[31], 32'h0040_0018);
        step(2);
        check("jr_pc", {dut.PC_reg.q, 2'b00}, 32'h0040_0018);
        for (int k = 0; k < 8 && dut.inst !== 32'h0; k++) step(1);
        check("halt_inst", dut.inst, 32'h0);
        check("halt_pc", {dut.PC_reg.q, 2'b00}, 32'h0040_001c);
        check("skip_r3", dut.rf.r[3], 32'h0000_dead);
        check("callee_r4", dut.rf.r[4], 32'd1);
        check("after_ret_r5", dut.rf.r[5], 32'd7);

        // Reset mid-program: PC returns at once, no writes while held
        begin_test();
        set_reg(2, 32'h0);
        release_reset();
        put_text(0, enc_i('h08, 0, 2, 1));
        for (int w = 1; w < 8; w++) put_text(w, enc_i('h08, 2, 2, 1));
        run_en = 1'b1;
        step(3);
        check("pre_reset_r2", dut.rf.r[2], 32'd3);
        @(posedge clk);
        #2;
        reset = 1'b0;
        mpc = TEXT_BASE;
        mtext.delete();
        #1;
        check("async_reset_pc", {dut.PC_reg.q, 2'b00}, 32'h0040_0000);
        step(2);
        check("held_reset_r2", dut.rf.r[2], 32'd4);

        // Random programs against the model
        for (int p = 0; p < 8; p++) begin
            begin_test();
            set_reg(1, DATA_BASE);
            set_reg(8, TEXT_BASE + 32'(4 * $urandom_range(0, PROG_LEN - 1)));
            set_reg(9, DATA_BASE - 32'd64);
            for (int i = 2; i < 8; i++) set_reg(i, $urandom());
            for (int k = 0; k < 16; k++) put_mem(k, $urandom());
            release_reset();
            for (int w = 0; w < PROG_LEN; w++) put_text(w, rand_inst());
            run_en = 1'b1;
            step(40);
            run_en = 1'b0;
            foreach (mmem[k]) check($sformatf("mem%0d", k), dut.data_memory.data_seg[k], mmem[k]);
        end

        run_en = 1'b0;
        step(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
